obi_mem_responder: RTL and testbench
====================================

Name: obi_mem_responder

Overview:
Memory-side responder for the core/cache req/gnt/rvalid protocol. It acts as the backing store behind the set-associative cache's mem_* port, and can equally sit behind a core data port directly. It holds a word-addressed SRAM array with byte-enable writes, a programmable grant delay and response latency, and flags out-of-range or misaligned accesses. It accepts one transaction at a time; with RSP_LATENCY=1 and GNT_DELAY=0 it sustains one access per cycle.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2, at least 2)
BASE_ADDR, 32'h0010_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS)
GNT_DELAY, 0, cycles req_i must be held high before gnt_o asserts (0..15)
RSP_LATENCY, 1, cycles from the grant cycle to the rvalid_o cycle (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_i  in  1  request, held high by the initiator until granted
addr_i  in  32  byte address
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables for writes; be_i[n] enables wdata_i[8n+7:8n]
wdata_i  in  32  write data
gnt_o  out  1  grant, combinational; the request is accepted in this cycle
rvalid_o  out  1  one-cycle response pulse, registered
rdata_o  out  32  read data, valid while rvalid_o is high, held afterwards
err_o  out  1  error flag, qualified by rvalid_o, registered

Behaviour:
- Reset (async, reset=1): state IDLE; grant counter 0; latency counter 0; rvalid_o=0, err_o=0, rdata_o=0. Array contents are not reset.
- States:
  - IDLE: no transaction pending.
  - STALL: req_i seen, grant delay counting.
  - BUSY: granted, latency counting.
- gnt_o = req_i && (state is IDLE or STALL) && (gnt_ctr == GNT_DELAY).
  - With GNT_DELAY=0, the grant is in the same cycle req_i first rises.
  - gnt_o is never asserted in BUSY.
- IDLE→STALL when req_i=1 and GNT_DELAY>0 (gnt_ctr becomes 1).
- STALL: gnt_ctr increments each cycle req_i=1.
  - If req_i drops before the grant: return to IDLE and clear gnt_ctr.
  - No transaction is recorded.
- Grant cycle (gnt_o=1), at the closing edge:
  - Capture addr_i, we_i, be_i.
  - Decode: err = addr_i[1:0]!=0, or addr_i outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Word index = addr_i[$clog2(DEPTH_WORDS)+1:2].
  - Write with no error: each enabled byte is written at this edge. be_i=0 leaves the word unchanged but still responds.
  - Read with no error: the array word is captured into an internal read register at this edge.
  - Error: no array access; response data = 32'h0.
  - Clear gnt_ctr.
  - If RSP_LATENCY==1: state→IDLE and arm the response for the next cycle. Otherwise state→BUSY with lat_ctr=1.
- BUSY: lat_ctr increments each cycle. When lat_ctr==RSP_LATENCY-1, at that edge: state→IDLE and assert rvalid_o in the next cycle.
- Response cycle:
  - rvalid_o=1 for exactly one cycle, exactly RSP_LATENCY cycles after the grant cycle.
  - err_o = captured err.
  - rdata_o = read data for reads; for writes, the post-write word (0 on error).
  - rdata_o and err_o hold their values until the next response.
- State is IDLE during the response cycle, so a new request can be granted in the same cycle rvalid_o is high. This gives back-to-back throughput when GNT_DELAY=0.
- Single outstanding transaction: the responder never grants a second request before the first rvalid.
- req_i is ignored in BUSY. The initiator may keep it high; it is granted after returning to IDLE, subject to GNT_DELAY counted from IDLE.
- Reset mid-transaction: the pending response is discarded (no rvalid_o). A write already committed at its grant edge remains in the array.
- Address decode uses full 32-bit compare; the top-of-range address BASE_ADDR+4*DEPTH_WORDS is an error.

Test Plan:
- GNT_DELAY=0, RSP_LATENCY=1. Write 32'hDEADBEEF to 0x0010_0010 with be=4'hF, then read it back → gnt in the same cycle as req; rvalid one cycle later; read returns 32'hDEADBEEF; err_o=0.
- Byte enables. After word=32'h11223344, write wdata=32'hAABBCCDD with be=4'b0101, then read → rdata 32'h11BB33DD.
- GNT_DELAY=3, RSP_LATENCY=4. Hold req from cycle 0 → gnt_o in cycle 3 only; rvalid_o in cycle 7 only. A second req held continuously is not granted before cycle 7.
- Errors. Read 0x0010_1000 (DEPTH 1024) and read 0x0010_0002 → rvalid with err_o=1, rdata 0. A write to 0x000F_FFFC returns err and leaves word 0 unchanged.
- Back-to-back reads of addresses 0x0010_0000, 0x0010_0004, 0x0010_0008 with req held (RSP_LATENCY=1) → three grants in consecutive cycles; rvalid high for three consecutive cycles with data in order.
- Reset asserted in BUSY (RSP_LATENCY=5, write granted) → no rvalid after reset; rdata_o=0. A later read of that address returns the written data.

Source files
------------

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: word-addressed SRAM behind a req/gnt/rvalid port.
// One transaction in flight; programmable grant delay and response latency;
// misaligned or out-of-window accesses respond with err_o and zero data.
module obi_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned GNT_DELAY   = 0,
    parameter int unsigned RSP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  GNT_LIM   = 4'(GNT_DELAY);
    localparam logic [3:0]  LAT_LAST  = 4'(RSP_LATENCY - 1);
    localparam bit          ONE_CYCLE = (RSP_LATENCY == 1);

    typedef enum logic [1:0] {IDLE, STALL, BUSY} state_e;

    state_e        state_q, state_d;
    logic [3:0]    gnt_ctr_q, gnt_ctr_d;
    logic [3:0]    lat_ctr_q, lat_ctr_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          addr_err;
    logic [31:0]   cur_word;
    logic [31:0]   wr_word;

    // Response captured at the grant edge, released when latency expires
    logic [31:0]   rd_q, rd_d;
    logic          err_q, err_d;
    logic          rsp_fire;

    logic          rvalid_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;

    // Address decode and write-merge; the window is aligned to its size,
    // so matching the upper address bits is the full range check
    always_comb begin
        idx      = addr_i[AW+1:2];
        addr_err = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != BASE_ADDR[31:AW+2]);
        cur_word = mem_q[idx];
        wr_word  = cur_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) wr_word[8*b +: 8] = wdata_i[8*b +: 8];
        end
        err_d = addr_err;
        rd_d  = '0;
        if (!addr_err) rd_d = we_i ? wr_word : cur_word;
    end

    // State register: FSM state and its grant/latency counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_ctr_q <= '0;
            lat_ctr_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_ctr_q <= gnt_ctr_d;
            lat_ctr_q <= lat_ctr_d;
        end
    end

    // Next-state logic: grant delay counting, then latency counting
    always_comb begin
        state_d   = state_q;
        gnt_ctr_d = gnt_ctr_q;
        lat_ctr_d = lat_ctr_q;
        unique case (state_q)
            IDLE, STALL: begin
                if (gnt_o) begin
                    gnt_ctr_d = '0;
                    if (ONE_CYCLE) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = BUSY;
                        lat_ctr_d = 4'd1;
                    end
                end else if (req_i) begin
                    state_d   = STALL;
                    gnt_ctr_d = gnt_ctr_q + 4'd1;
                end else begin
                    state_d   = IDLE;
                    gnt_ctr_d = '0;
                end
            end
            BUSY: begin
                if (lat_ctr_q == LAT_LAST) begin
                    state_d   = IDLE;
                    lat_ctr_d = '0;
                end else begin
                    lat_ctr_d = lat_ctr_q + 4'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_ctr_d = '0;
                lat_ctr_d = '0;
            end
        endcase
    end

    // Output logic: combinational grant and response-release strobe
    always_comb begin
        gnt_o    = req_i && (state_q != BUSY) && (gnt_ctr_q == GNT_LIM);
        rsp_fire = (gnt_o && ONE_CYCLE) || ((state_q == BUSY) && (lat_ctr_q == LAT_LAST));
    end

    // Array write at the grant edge; contents survive reset
    always_ff @(posedge clk) begin
        if (gnt_o && we_i && !addr_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Capture response data/error for the granted access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else if (gnt_o) begin
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    // Response registers: one-cycle rvalid pulse, data/err held until next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rvalid_q <= rsp_fire;
            if (rsp_fire) begin
                // Single-cycle latency releases straight from the grant cycle
                rsp_data_q <= ONE_CYCLE ? rd_d : rd_q;
                rsp_err_q  <= ONE_CYCLE ? err_d : err_q;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rsp_data_q;
    assign err_o    = rsp_err_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: three instances with different
// grant-delay / latency settings, each driven through hand-computed steps.
module tb_obi_mem_responder;

    logic clk;
    logic rst_a, rst_b, rst_c;

    logic        a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_be;

    int n_chk  = 0;
    int n_fail = 0;

    obi_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0010_0000),
                        .GNT_DELAY(0), .RSP_LATENCY(1)) u_a (
        .clk(clk), .reset(rst_a), .req_i(a_req), .addr_i(a_addr), .we_i(a_we),
        .be_i(a_be), .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
        .rdata_o(a_rdata), .err_o(a_err));

    obi_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0010_0000),
                        .GNT_DELAY(3), .RSP_LATENCY(4)) u_b (
        .clk(clk), .reset(rst_b), .req_i(b_req), .addr_i(b_addr), .we_i(b_we),
        .be_i(b_be), .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
        .rdata_o(b_rdata), .err_o(b_err));

    obi_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0010_0000),
                        .GNT_DELAY(0), .RSP_LATENCY(5)) u_c (
        .clk(clk), .reset(rst_c), .req_i(c_req), .addr_i(c_addr), .we_i(c_we),
        .be_i(c_be), .wdata_i(c_wdata), .gnt_o(c_gnt), .rvalid_o(c_rvalid),
        .rdata_o(c_rdata), .err_o(c_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single access on instance A: grant in the request cycle, response next cycle
    task automatic a_xact(input string tag, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        a_req = 1'b1; a_addr = addr; a_we = we; a_be = be; a_wdata = wdata;
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, 32'(a_rvalid), 32'd1);
        rdata = a_rdata;
        err   = a_err;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        rq, wv, eg, ev;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
        c_req = 0; c_we = 0; c_be = '0; c_addr = '0; c_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_err",    32'(a_err),    32'd0);
        chk("rst_rdata",  a_rdata,       32'h0);
        chk("rst_gnt",    32'(a_gnt),    32'd0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // ---- Instance A: basic write / read-back ----
        a_xact("wr_dead", 32'h0010_0010, 1'b1, 4'hF, 32'hDEADBEEF, rd, er);
        chk("wr_dead_data", rd, 32'hDEADBEEF);
        chk("wr_dead_err", 32'(er), 32'd0);
        a_xact("rd_dead", 32'h0010_0010, 1'b0, 4'h0, 32'h0, rd, er);
        chk("rd_dead_data", rd, 32'hDEADBEEF);
        chk("rd_dead_err", 32'(er), 32'd0);
        // data holds after the pulse
        @(negedge clk);
        chk("hold_rvalid", 32'(a_rvalid), 32'd0);
        chk("hold_rdata", a_rdata, 32'hDEADBEEF);

        // Byte enables
        a_xact("wr_base", 32'h0010_0020, 1'b1, 4'hF, 32'h11223344, rd, er);
        a_xact("wr_be", 32'h0010_0020, 1'b1, 4'b0101, 32'hAABBCCDD, rd, er);
        chk("wr_be_data", rd, 32'h11BB33DD);
        a_xact("rd_be", 32'h0010_0020, 1'b0, 4'h0, 32'h0, rd, er);
        chk("rd_be_data", rd, 32'h11BB33DD);
        a_xact("wr_be0", 32'h0010_0020, 1'b1, 4'h0, 32'hFFFFFFFF, rd, er);
        chk("wr_be0_data", rd, 32'h11BB33DD);
        chk("wr_be0_err", 32'(er), 32'd0);

        // Errors
        a_xact("wr_w0", 32'h0010_0000, 1'b1, 4'hF, 32'hCAFEF00D, rd, er);
        a_xact("rd_top", 32'h0010_1000, 1'b0, 4'h0, 32'h0, rd, er);
        chk("rd_top_err", 32'(er), 32'd1);
        chk("rd_top_data", rd, 32'h0);
        a_xact("rd_mis", 32'h0010_0002, 1'b0, 4'h0, 32'h0, rd, er);
        chk("rd_mis_err", 32'(er), 32'd1);
        chk("rd_mis_data", rd, 32'h0);
        a_xact("wr_low", 32'h000F_FFFC, 1'b1, 4'hF, 32'h12345678, rd, er);
        chk("wr_low_err", 32'(er), 32'd1);
        chk("wr_low_data", rd, 32'h0);
        a_xact("rd_w0", 32'h0010_0000, 1'b0, 4'h0, 32'h0, rd, er);
        chk("rd_w0_data", rd, 32'hCAFEF00D);
        chk("rd_w0_err", 32'(er), 32'd0);
        a_xact("wr_last", 32'h0010_0FFC, 1'b1, 4'hF, 32'h0F0F0F0F, rd, er);
        chk("wr_last_err", 32'(er), 32'd0);
        chk("wr_last_data", rd, 32'h0F0F0F0F);

        // Back-to-back reads with req held
        a_xact("wr_w1", 32'h0010_0004, 1'b1, 4'hF, 32'h44444444, rd, er);
        a_xact("wr_w2", 32'h0010_0008, 1'b1, 4'hF, 32'h88888888, rd, er);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0010_0000;
        @(negedge clk);
        chk("b2b_gnt0", 32'(a_gnt), 32'd1);
        chk("b2b_rv0", 32'(a_rvalid), 32'd0);
        @(posedge clk); #1;
        a_addr = 32'h0010_0004;
        @(negedge clk);
        chk("b2b_gnt1", 32'(a_gnt), 32'd1);
        chk("b2b_rv1", 32'(a_rvalid), 32'd1);
        chk("b2b_d1", a_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        a_addr = 32'h0010_0008;
        @(negedge clk);
        chk("b2b_gnt2", 32'(a_gnt), 32'd1);
        chk("b2b_rv2", 32'(a_rvalid), 32'd1);
        chk("b2b_d2", a_rdata, 32'h44444444);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk("b2b_gnt3", 32'(a_gnt), 32'd0);
        chk("b2b_rv3", 32'(a_rvalid), 32'd1);
        chk("b2b_d3", a_rdata, 32'h88888888);
        @(negedge clk);
        chk("b2b_rv4", 32'(a_rvalid), 32'd0);

        // ---- Instance B: GNT_DELAY=3, RSP_LATENCY=4 ----
        // c0-c1 req then drop (stall abort); c3..c6 write granted at c6;
        // req held as a read from c7, granted at c13 (3 after IDLE at c10);
        // responses at c10 (write) and c17 (read).
        b_addr = 32'h0010_0040; b_wdata = 32'h0BADCAFE; b_be = 4'hF;
        for (int c = 0; c < 19; c++) begin
            rq = (c <= 1) || (c >= 3 && c <= 13);
            wv = (c < 7);
            eg = (c == 6) || (c == 13);
            ev = (c == 10) || (c == 17);
            @(posedge clk); #1;
            b_req = rq; b_we = wv;
            @(negedge clk);
            chk($sformatf("b_gnt_c%0d", c), 32'(b_gnt), 32'(eg));
            chk($sformatf("b_rvalid_c%0d", c), 32'(b_rvalid), 32'(ev));
            if (ev) begin
                chk($sformatf("b_rdata_c%0d", c), b_rdata, 32'h0BADCAFE);
                chk($sformatf("b_err_c%0d", c), 32'(b_err), 32'd0);
            end
        end

        // ---- Instance C: RSP_LATENCY=5, reset mid-transaction ----
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_be = 4'hF; c_addr = 32'h0010_0084; c_wdata = 32'h00000077;
        @(negedge clk);
        chk("c_pre_gnt", 32'(c_gnt), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            c_req = 1'b0;
            @(negedge clk);
            chk($sformatf("c_pre_rv%0d", k), 32'(c_rvalid), 32'(k == 5));
        end
        chk("c_pre_data", c_rdata, 32'h00000077);

        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h0010_0080; c_wdata = 32'h5A5A1234;
        @(negedge clk);
        chk("c_wr_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        chk("c_busy_rv", 32'(c_rvalid), 32'd0);
        @(posedge clk); #1;
        rst_c = 1'b1;
        @(negedge clk);
        chk("c_rst_rdata", c_rdata, 32'h0);
        chk("c_rst_rv", 32'(c_rvalid), 32'd0);
        @(posedge clk); #1;
        rst_c = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("c_post_rv%0d", k), 32'(c_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0010_0080;
        @(negedge clk);
        chk("c_rd_gnt", 32'(c_gnt), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            c_req = 1'b0;
            @(negedge clk);
            chk($sformatf("c_rd_rv%0d", k), 32'(c_rvalid), 32'(k == 5));
        end
        chk("c_rd_data", c_rdata, 32'h5A5A1234);
        chk("c_rd_err", 32'(c_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
